// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Host-to-device PS/2 transmitter. Holds the clock line low to inhibit
// the device, then requests to send and shifts out one byte frame:
// start bit, 8 data bits LSB first, odd parity and stop. It then reads
// the device ACK. The data line only changes after a detected device
// clock falling edge.
//
// Ports
//   CLOCK_50   in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   start      in   send request, sampled only while idle
//   tx_data    in   byte to send
//   PS2_CLK    in   PS/2 clock line at the pin
//   PS2_DAT    in   PS/2 data line at the pin
//   ps2_clk_oe out  1 = pull clock line low
//   ps2_dat_oe out  1 = pull data line low
//   busy       out  frame in progress
//   done       out  one-cycle frame-complete pulse
//   ack_ok     out  device acknowledged (valid with done)
//   error      out  one-cycle timeout-abort pulse
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_data,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       error
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_DATA      = 3'd3,
        ST_PARITY    = 3'd4,
        ST_STOP      = 3'd5,
        ST_ACK       = 3'd6,
        ST_WAIT_IDLE = 3'd7
    } state_t;

    // Odd parity bit: 1 when the byte has an even number of ones.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    state_t             state_r, next_state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic [2:0]         bit_idx_r, bit_idx_nxt_s, bit_idx_inc_s;
    logic [7:0]         data_r, data_nxt_s;
    logic               parity_r, parity_nxt_s;
    logic               dat_oe_r, dat_oe_nxt_s;
    logic               ack_r, ack_nxt_s;
    logic               clk_oe_r, busy_r, done_r, error_r, error_nxt_s;
    logic               clk_meta_r, clk_sync_r, clk_prev_r;
    logic               dat_meta_r, dat_sync_r;
    logic               fe_s, in_frame_s, timeout_s;

    assign bit_idx_inc_s = bit_idx_r + 3'd1;
    assign fe_s          = clk_prev_r & ~clk_sync_r;
    assign in_frame_s    = (state_r == ST_REQ) || (state_r == ST_DATA) || (state_r == ST_PARITY) ||
                           (state_r == ST_STOP) || (state_r == ST_ACK);
    // Fires one cycle before the counter would reach the limit, so the
    // abort is visible exactly TIMEOUT_CYCLES cycles after the last clear.
    // A falling edge in that same cycle clears the counter instead.
    assign timeout_s     = in_frame_s && !fe_s && (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // Next-state, counters and next values of the registered outputs.
    always_comb begin
        next_state_s  = state_r;
        cnt_nxt_s     = cnt_r;
        bit_idx_nxt_s = bit_idx_r;
        data_nxt_s    = data_r;
        parity_nxt_s  = parity_r;
        dat_oe_nxt_s  = dat_oe_r;
        ack_nxt_s     = ack_r;
        error_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                dat_oe_nxt_s = 1'b0;
                if (start) begin
                    data_nxt_s    = tx_data;
                    parity_nxt_s  = odd_parity(tx_data);
                    cnt_nxt_s     = {CNT_W{1'b0}};
                    bit_idx_nxt_s = 3'd0;
                    ack_nxt_s     = 1'b0;
                    next_state_s  = ST_INHIBIT;
                end else begin
                    cnt_nxt_s     = {CNT_W{1'b0}};
                end
            end
            ST_INHIBIT: begin
                if (cnt_r == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    cnt_nxt_s    = {CNT_W{1'b0}};
                    dat_oe_nxt_s = 1'b1;
                    next_state_s = ST_REQ;
                end else begin
                    cnt_nxt_s    = cnt_r + CNT_W'(1);
                end
            end
            ST_REQ: begin
                if (fe_s) begin
                    cnt_nxt_s     = {CNT_W{1'b0}};
                    bit_idx_nxt_s = 3'd0;
                    dat_oe_nxt_s  = ~data_r[0];
                    next_state_s  = ST_DATA;
                end else begin
                    cnt_nxt_s     = cnt_r + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (fe_s) begin
                    cnt_nxt_s = {CNT_W{1'b0}};
                    if (bit_idx_r == 3'd7) begin
                        dat_oe_nxt_s  = ~parity_r;
                        next_state_s  = ST_PARITY;
                    end else begin
                        bit_idx_nxt_s = bit_idx_inc_s;
                        dat_oe_nxt_s  = ~data_r[bit_idx_inc_s];
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_PARITY: begin
                if (fe_s) begin
                    cnt_nxt_s    = {CNT_W{1'b0}};
                    dat_oe_nxt_s = 1'b0;
                    next_state_s = ST_STOP;
                end else begin
                    cnt_nxt_s    = cnt_r + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (fe_s) begin
                    cnt_nxt_s    = {CNT_W{1'b0}};
                    ack_nxt_s    = ~dat_sync_r;
                    next_state_s = ST_ACK;
                end else begin
                    cnt_nxt_s    = cnt_r + CNT_W'(1);
                end
            end
            ST_ACK: begin
                if (clk_sync_r && dat_sync_r) begin
                    cnt_nxt_s    = {CNT_W{1'b0}};
                    next_state_s = ST_WAIT_IDLE;
                end else if (fe_s) begin
                    cnt_nxt_s    = {CNT_W{1'b0}};
                end else begin
                    cnt_nxt_s    = cnt_r + CNT_W'(1);
                end
            end
            ST_WAIT_IDLE: begin
                dat_oe_nxt_s = 1'b0;
                next_state_s = ST_IDLE;
            end
            default: begin
                dat_oe_nxt_s = 1'b0;
                cnt_nxt_s    = {CNT_W{1'b0}};
                next_state_s = ST_IDLE;
            end
        endcase
        if (timeout_s) begin
            cnt_nxt_s    = {CNT_W{1'b0}};
            dat_oe_nxt_s = 1'b0;
            error_nxt_s  = 1'b1;
            next_state_s = ST_IDLE;
        end else begin
            error_nxt_s  = 1'b0;
        end
    end

    // State, datapath, synchronizers and registered outputs.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            bit_idx_r  <= 3'd0;
            data_r     <= 8'h00;
            parity_r   <= 1'b0;
            dat_oe_r   <= 1'b0;
            ack_r      <= 1'b0;
            clk_oe_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            clk_meta_r <= 1'b1;
            clk_sync_r <= 1'b1;
            clk_prev_r <= 1'b1;
            dat_meta_r <= 1'b1;
            dat_sync_r <= 1'b1;
        end else begin
            state_r    <= next_state_s;
            cnt_r      <= cnt_nxt_s;
            bit_idx_r  <= bit_idx_nxt_s;
            data_r     <= data_nxt_s;
            parity_r   <= parity_nxt_s;
            dat_oe_r   <= dat_oe_nxt_s;
            ack_r      <= ack_nxt_s;
            clk_oe_r   <= (next_state_s == ST_INHIBIT);
            busy_r     <= (next_state_s != ST_IDLE);
            done_r     <= (next_state_s == ST_WAIT_IDLE);
            error_r    <= error_nxt_s;
            clk_meta_r <= PS2_CLK;
            clk_sync_r <= clk_meta_r;
            clk_prev_r <= clk_sync_r;
            dat_meta_r <= PS2_DAT;
            dat_sync_r <= dat_meta_r;
        end
    end

    assign ps2_clk_oe = clk_oe_r;
    assign ps2_dat_oe = dat_oe_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign ack_ok     = ack_r;
    assign error      = error_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
// Drives ps2_host_tx against a behavioural PS/2 keyboard model on
// open-drain lines and compares the captured frames with a reference
// built from the framing rules (start 0, data LSB first, odd parity, stop 1).
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INH = 6000;
    localparam int TO  = 400;
    localparam int H   = 40;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b0;
    logic       start    = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       PS2_CLK, PS2_DAT;
    logic       ps2_clk_oe, ps2_dat_oe, busy, done, ack_ok, error;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int done_cnt  = 0;
    int error_cnt = 0;
    int both_cnt  = 0;
    int inh_run   = 0;
    int last_inh  = 0;
    int viol_cnt  = 0;
    int busy_viol = 0;
    bit   mon_en      = 1'b0;
    logic prev_dat_oe = 1'b0;
    logic prev_done   = 1'b0;

    assign PS2_CLK = ~(ps2_clk_oe | dev_clk_low);
    assign PS2_DAT = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .start     (start),
        .tx_data   (tx_data),
        .PS2_CLK   (PS2_CLK),
        .PS2_DAT   (PS2_DAT),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .busy      (busy),
        .done      (done),
        .ack_ok    (ack_ok),
        .error     (error)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Event counters and line-discipline monitor.
    always @(negedge CLOCK_50) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (error === 1'b1) error_cnt <= error_cnt + 1;
        if (done === 1'b1 && error === 1'b1) both_cnt <= both_cnt + 1;
        if (ps2_clk_oe === 1'b1) inh_run <= inh_run + 1;
        else if (inh_run != 0) begin
            last_inh <= inh_run;
            inh_run  <= 0;
        end
        if (mon_en && (ps2_dat_oe !== prev_dat_oe) && !dev_clk_low) viol_cnt <= viol_cnt + 1;
        prev_dat_oe <= ps2_dat_oe;
        if (prev_done === 1'b1 && busy !== 1'b0) busy_viol <= busy_viol + 1;
        prev_done <= done;
    end

    // Expected line levels: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] model_bits(input logic [7:0] d);
        logic [10:0] b;
        int ones;
        ones = 0;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b[i+1] = d[i];
            ones   = ones + ((int'(d) >> i) & 1);
        end
        b[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
        b[10] = 1'b1;
        return b;
    endfunction

    // Keyboard model: waits for the request, gives n_fe clocks (period 2H),
    // samples the line before each falling edge, optionally ACKs at clock 11.
    task automatic dev_frame(input bit do_ack, input int n_fe, output logic [10:0] bits, output bit req_seen);
        int t;
        t = 0;
        bits = 11'h7FF;
        while (!(ps2_dat_oe === 1'b1 && ps2_clk_oe === 1'b0) && t < 20000) begin
            @(negedge CLOCK_50);
            t++;
        end
        req_seen = (t < 20000);
        if (req_seen) begin
            for (int i = 1; i <= 11; i++) begin
                if (i <= n_fe) begin
                    repeat (H/2) @(negedge CLOCK_50);
                    if (i == 1) mon_en = 1'b1;
                    bits[i-1] = PS2_DAT;
                    if (i == 11 && do_ack) dev_dat_low = 1'b1;
                    repeat (H/2) @(negedge CLOCK_50);
                    dev_clk_low = 1'b1;
                    repeat (H) @(negedge CLOCK_50);
                    dev_clk_low = 1'b0;
                    if (i == 10) mon_en = 1'b0;
                end
            end
            repeat (H/2) @(negedge CLOCK_50);
            dev_dat_low = 1'b0;
        end
        mon_en = 1'b0;
    endtask

    // One full frame with checks. glitch pulses start with 0xFF mid-frame;
    // chain starts the next byte in the cycle done is seen; skip_start
    // means the start was already issued by a chained predecessor.
    task automatic do_frame(input string name, input logic [7:0] d, input bit do_ack, input bit glitch,
                            input bit skip_start, input bit chain, input logic [7:0] chain_d,
                            output logic [10:0] got);
        logic [10:0] exp;
        bit   req_seen, got_done;
        logic ack_at_done;
        int   d0, e0, t;
        exp = model_bits(d);
        d0 = done_cnt; e0 = error_cnt;
        got_done = 1'b0; ack_at_done = 1'b0; t = 0;
        if (!skip_start) begin
            start = 1'b1; tx_data = d;
            @(negedge CLOCK_50);
            start = 1'b0; tx_data = 8'($urandom);
            total_cnt++;
            if (busy !== 1'b1) $display("FAIL %s busy_after_start got=%b exp=1", name, busy);
            else pass_cnt++;
        end
        fork
            dev_frame(do_ack, 11, got, req_seen);
            begin
                if (glitch) begin
                    repeat (6500) @(negedge CLOCK_50);
                    start = 1'b1; tx_data = 8'hFF;
                    @(negedge CLOCK_50);
                    start = 1'b0;
                end
            end
            begin
                while (done !== 1'b1 && t < 20000) begin
                    @(negedge CLOCK_50);
                    t++;
                end
                got_done = (done === 1'b1);
                ack_at_done = ack_ok;
                if (chain) begin
                    start = 1'b1; tx_data = chain_d;
                    @(negedge CLOCK_50);
                    total_cnt++;
                    if (busy !== 1'b0) $display("FAIL %s busy_falls got=%b exp=0", name, busy);
                    else pass_cnt++;
                    @(negedge CLOCK_50);
                    start = 1'b0;
                    total_cnt++;
                    if (busy !== 1'b1 || ps2_clk_oe !== 1'b1)
                        $display("FAIL %s chained_start busy=%b clk_oe=%b exp=1,1", name, busy, ps2_clk_oe);
                    else pass_cnt++;
                end
            end
        join
        @(negedge CLOCK_50);
        total_cnt++;
        if (req_seen !== 1'b1 || got_done !== 1'b1)
            $display("FAIL %s handshake req=%b done=%b exp=1,1", name, req_seen, got_done);
        else pass_cnt++;
        total_cnt++;
        if (got !== exp) $display("FAIL %s line_bits got=%b exp=%b", name, got, exp);
        else pass_cnt++;
        total_cnt++;
        if (ack_at_done !== do_ack) $display("FAIL %s ack_ok got=%b exp=%b", name, ack_at_done, do_ack);
        else pass_cnt++;
        total_cnt++;
        if (last_inh != INH) $display("FAIL %s inhibit_len got=%0d exp=%0d", name, last_inh, INH);
        else pass_cnt++;
        total_cnt++;
        if (done_cnt - d0 != 1 || error_cnt != e0)
            $display("FAIL %s pulses done=%0d err=%0d exp=1,0", name, done_cnt - d0, error_cnt - e0);
        else pass_cnt++;
        if (!chain) begin
            total_cnt++;
            if (busy !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0)
                $display("FAIL %s idle_after busy=%b clk_oe=%b dat_oe=%b exp=0,0,0", name, busy, ps2_clk_oe, ps2_dat_oe);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        total_cnt++;
        if ({ps2_clk_oe, ps2_dat_oe, busy, done, ack_ok, error} !== 6'b0)
            $display("FAIL reset_outputs got=%b exp=000000", {ps2_clk_oe, ps2_dat_oe, busy, done, ack_ok, error});
        else pass_cnt++;
        reset = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        total_cnt++;
        if (busy !== 1'b0 || ps2_clk_oe !== 1'b0) $display("FAIL reset_idle busy=%b clk_oe=%b exp=0,0", busy, ps2_clk_oe);
        else pass_cnt++;
    endtask

    task automatic test_ack_ed();
        logic [10:0] g;
        do_frame("ack_ed", 8'hED, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, g);
    endtask

    task automatic test_nack_ed();
        logic [10:0] g;
        do_frame("nack_ed", 8'hED, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, g);
    endtask

    task automatic test_start_ignored();
        logic [10:0] g;
        do_frame("start_ignored", 8'hED, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, g);
    endtask

    task automatic test_timeout();
        int d0, e0, t, n;
        d0 = done_cnt; e0 = error_cnt; t = 0; n = 0;
        start = 1'b1; tx_data = 8'($urandom);
        @(negedge CLOCK_50);
        start = 1'b0;
        while (!(ps2_dat_oe === 1'b1 && ps2_clk_oe === 1'b0) && t < 20000) begin
            @(negedge CLOCK_50);
            t++;
        end
        while (error !== 1'b1 && n < TO + 100) begin
            @(negedge CLOCK_50);
            n++;
        end
        total_cnt++;
        if (error !== 1'b1 || n != TO) $display("FAIL timeout_delay got=%0d err=%b exp=%0d", n, error, TO);
        else pass_cnt++;
        total_cnt++;
        if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || busy !== 1'b0)
            $display("FAIL timeout_release clk_oe=%b dat_oe=%b busy=%b exp=0,0,0", ps2_clk_oe, ps2_dat_oe, busy);
        else pass_cnt++;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        total_cnt++;
        if (error_cnt - e0 != 1 || done_cnt != d0)
            $display("FAIL timeout_pulses err=%0d done=%0d exp=1,0", error_cnt - e0, done_cnt - d0);
        else pass_cnt++;
    endtask

    task automatic test_reset_midframe();
        logic [10:0] g;
        bit req;
        int d0, e0;
        start = 1'b1; tx_data = 8'hED;
        @(negedge CLOCK_50);
        start = 1'b0;
        dev_frame(1'b1, 5, g, req);
        total_cnt++;
        if (ps2_dat_oe !== 1'b1) $display("FAIL midframe_bit4 dat_oe=%b exp=1", ps2_dat_oe);
        else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++;
        if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || busy !== 1'b0)
            $display("FAIL midframe_reset clk_oe=%b dat_oe=%b busy=%b exp=0,0,0", ps2_clk_oe, ps2_dat_oe, busy);
        else pass_cnt++;
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b1;
        d0 = done_cnt; e0 = error_cnt;
        repeat (2 * TO) @(negedge CLOCK_50);
        total_cnt++;
        if (done_cnt != d0 || error_cnt != e0 || busy !== 1'b0)
            $display("FAIL after_reset done=%0d err=%0d busy=%b exp=0,0,0", done_cnt - d0, error_cnt - e0, busy);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [10:0] g;
        do_frame("b2b_00", 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, g);
        total_cnt++;
        if (g[9] !== 1'b1) $display("FAIL parity_00 got=%b exp=1", g[9]);
        else pass_cnt++;
        do_frame("b2b_01", 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, g);
        total_cnt++;
        if (g[9] !== 1'b0) $display("FAIL parity_01 got=%b exp=0", g[9]);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [10:0] g;
        for (int k = 0; k < 2; k++) begin
            do_frame("random", 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 8'h00, g);
        end
    endtask

    task automatic test_line_discipline();
        total_cnt++;
        if (viol_cnt != 0) $display("FAIL data_change_clk_high got=%0d exp=0", viol_cnt);
        else pass_cnt++;
        total_cnt++;
        if (busy_viol != 0) $display("FAIL busy_after_done got=%0d exp=0", busy_viol);
        else pass_cnt++;
        total_cnt++;
        if (both_cnt != 0) $display("FAIL done_with_error got=%0d exp=0", both_cnt);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_ack_ed();
        test_nack_ed();
        test_timeout();
        test_start_ignored();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        test_line_discipline();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
